// File: rtl/div_seq_pkg.sv
// Shared types and sizing for the sequential restoring divider (div_seq).
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_e;

  // Two's-complement negate when neg is set; also used to take magnitudes.
  function automatic logic [DIV_WIDTH-1:0] condNeg(input logic [DIV_WIDTH-1:0] v, input logic neg);
    if (neg) begin
      condNeg = ~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      condNeg = v;
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring radix-2 division iteration.
module div_step
  import div_seq_pkg::*;
(
  input  logic [DIV_WIDTH:0]   remIn,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 nextBit,
  output logic [DIV_WIDTH:0]   remOut,
  output logic                 qBit
);

  logic [DIV_WIDTH+1:0] shifted_s;

  // Shift in the next dividend bit, trial-subtract, restore on a negative result.
  always_comb begin
    shifted_s = {remIn, nextBit};
    qBit      = (shifted_s >= {2'b00, divisor});
    if (qBit) begin
      remOut = shifted_s[DIV_WIDTH:0] - {1'b0, divisor};
    end else begin
      remOut = shifted_s[DIV_WIDTH:0];
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit DIV/DIVU unit: 32 restoring iterations, one-cycle DONE.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero skips straight to DONE.
module div_seq
  import div_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic                 flush,
  input  logic [DIV_WIDTH-1:0] opa,
  input  logic [DIV_WIDTH-1:0] opb,
  output logic                 divstall,
  output logic                 result_valid,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder
);

  divState_e              state_r;
  divState_e              stateNext_s;
  logic [DIV_CNT_W-1:0]   cnt_r;
  logic [DIV_WIDTH-1:0]   dividend_r;
  logic [DIV_WIDTH-1:0]   divisor_r;
  logic [DIV_WIDTH:0]     rem_r;
  logic [DIV_WIDTH-2:0]   quot_r;
  logic                   qSign_r;
  logic                   rSign_r;
  logic [DIV_WIDTH-1:0]   quotient_r;
  logic [DIV_WIDTH-1:0]   remainder_r;

  logic                   accept_s;
  logic                   lastIter_s;
  logic                   qSignIn_s;
  logic                   rSignIn_s;
  logic [DIV_WIDTH-1:0]   opaAbs_s;
  logic [DIV_WIDTH-1:0]   opbAbs_s;
  logic [DIV_WIDTH:0]     stepRem_s;
  logic                   stepQ_s;
  logic [DIV_WIDTH-1:0]   finalQ_s;
  logic [DIV_WIDTH-1:0]   finalR_s;

  div_step uStep (
    .remIn   (rem_r),
    .divisor (divisor_r),
    .nextBit (dividend_r[DIV_WIDTH-1]),
    .remOut  (stepRem_s),
    .qBit    (stepQ_s)
  );

  assign accept_s   = (state_r == IDLE) & start & ~flush;
  assign lastIter_s = (cnt_r == DIV_CNT_W'(DIV_ITER - 1));
  assign qSignIn_s  = signed_div & (opa[DIV_WIDTH-1] ^ opb[DIV_WIDTH-1]);
  assign rSignIn_s  = signed_div & opa[DIV_WIDTH-1];
  assign opaAbs_s   = condNeg(opa, signed_div & opa[DIV_WIDTH-1]);
  assign opbAbs_s   = condNeg(opb, signed_div & opb[DIV_WIDTH-1]);
  assign finalQ_s   = {quot_r, stepQ_s};
  assign finalR_s   = stepRem_s[DIV_WIDTH-1:0];

  // Stall covers the acceptance cycle and all of BUSY; it drops in DONE and on flush.
  assign divstall     = resetn & ~flush & (((state_r == IDLE) & start) | (state_r == BUSY));
  assign result_valid = (state_r == DONE) & ~flush;
  assign quotient     = quotient_r;
  assign remainder    = remainder_r;

  // Next-state logic; flush wins from any state.
  always_comb begin
    stateNext_s = state_r;
    if (flush) begin
      stateNext_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
`ifdef DIV_ZERO_FAST_EN
            if (opb == {DIV_WIDTH{1'b0}}) begin
              stateNext_s = DONE;
            end else begin
              stateNext_s = BUSY;
            end
`else
            stateNext_s = BUSY;
`endif
          end else begin
            stateNext_s = IDLE;
          end
        end
        BUSY: begin
          if (lastIter_s) begin
            stateNext_s = DONE;
          end else begin
            stateNext_s = BUSY;
          end
        end
        DONE:    stateNext_s = IDLE;
        default: stateNext_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Operand capture, iteration datapath and sign-corrected result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_r       <= {DIV_CNT_W{1'b0}};
      dividend_r  <= {DIV_WIDTH{1'b0}};
      divisor_r   <= {DIV_WIDTH{1'b0}};
      rem_r       <= {(DIV_WIDTH+1){1'b0}};
      quot_r      <= {(DIV_WIDTH-1){1'b0}};
      qSign_r     <= 1'b0;
      rSign_r     <= 1'b0;
      quotient_r  <= {DIV_WIDTH{1'b0}};
      remainder_r <= {DIV_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r      <= {DIV_CNT_W{1'b0}};
            dividend_r <= opaAbs_s;
            divisor_r  <= opbAbs_s;
            rem_r      <= {(DIV_WIDTH+1){1'b0}};
            quot_r     <= {(DIV_WIDTH-1){1'b0}};
            qSign_r    <= qSignIn_s;
            rSign_r    <= rSignIn_s;
`ifdef DIV_ZERO_FAST_EN
            if (opb == {DIV_WIDTH{1'b0}}) begin
              quotient_r  <= condNeg({DIV_WIDTH{1'b1}}, qSignIn_s);
              remainder_r <= condNeg(opaAbs_s, rSignIn_s);
            end
`endif
          end
        end
        BUSY: begin
          if (!flush) begin
            cnt_r      <= cnt_r + {{(DIV_CNT_W-1){1'b0}}, 1'b1};
            rem_r      <= stepRem_s;
            quot_r     <= finalQ_s[DIV_WIDTH-2:0];
            dividend_r <= {dividend_r[DIV_WIDTH-2:0], 1'b0};
            if (lastIter_s) begin
              quotient_r  <= condNeg(finalQ_s, qSign_r);
              remainder_r <= condNeg(finalR_s, rSign_r);
            end
          end
        end
        DONE: begin
          cnt_r <= {DIV_CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {DIV_CNT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (honours DIV_ZERO_FAST_EN if defined).
module tb_div_seq;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic        flush;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        divstall;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int nTests;
  int nFail;

  div_seq dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .signed_div   (signed_div),
    .flush        (flush),
    .opa          (opa),
    .opb          (opb),
    .divstall     (divstall),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
  localparam int DBZ_LAT = 1;
`else
  localparam int DBZ_LAT = 33;
`endif

  // Issue one divide holding start until result_valid; returns latency (cycle of valid,
  // acceptance = 0), count of divstall-high cycles, and the captured results.
  task automatic doDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output int lat, output int stalls,
                       output logic [31:0] q, output logic [31:0] r);
    int cyc;
    bit got;
    cyc = 0; got = 1'b0; stalls = 0; lat = -1; q = 32'hDEAD_BEEF; r = 32'hDEAD_BEEF;
    @(negedge clk);
    opa = a; opb = b; signed_div = sgn; flush = 1'b0; start = 1'b1;
    while (cyc < 100 && !got) begin
      #1;
      if (result_valid) begin
        got = 1'b1; lat = cyc; q = quotient; r = remainder; start = 1'b0;
      end else begin
        if (divstall) stalls++;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b1; signed_div = 1'b0; flush = 1'b0; opa = 32'd100; opb = 32'd7;
    #2;
    nTests++; if (divstall !== 1'b0) begin nFail++; $display("FAIL reset_divstall got %b exp 0", divstall); end
    nTests++; if (result_valid !== 1'b0) begin nFail++; $display("FAIL reset_valid got %b exp 0", result_valid); end
    nTests++; if (quotient !== 32'd0) begin nFail++; $display("FAIL reset_quotient got %h exp 0", quotient); end
    nTests++; if (remainder !== 32'd0) begin nFail++; $display("FAIL reset_remainder got %h exp 0", remainder); end
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_divu();
    int lat, st; logic [31:0] q, r;
    doDiv(32'd100, 32'd7, 1'b0, lat, st, q, r);
    nTests++; if (lat !== 33) begin nFail++; $display("FAIL divu_latency got %0d exp 33", lat); end
    nTests++; if (st !== 33) begin nFail++; $display("FAIL divu_stall_cycles got %0d exp 33", st); end
    nTests++; if (q !== 32'd14) begin nFail++; $display("FAIL divu_quotient got %h exp %h", q, 32'd14); end
    nTests++; if (r !== 32'd2) begin nFail++; $display("FAIL divu_remainder got %h exp %h", r, 32'd2); end
    @(negedge clk); #1;
    nTests++; if (result_valid !== 1'b0) begin nFail++; $display("FAIL divu_valid_one_cycle got %b exp 0", result_valid); end
    nTests++; if (quotient !== 32'd14) begin nFail++; $display("FAIL divu_quotient_hold got %h exp %h", quotient, 32'd14); end
    doDiv(32'hFFFF_FFF9, 32'd2, 1'b0, lat, st, q, r);
    nTests++; if (q !== 32'h7FFF_FFFC) begin nFail++; $display("FAIL divu_big_quotient got %h exp %h", q, 32'h7FFF_FFFC); end
    nTests++; if (r !== 32'd1) begin nFail++; $display("FAIL divu_big_remainder got %h exp %h", r, 32'd1); end
  endtask

  task automatic test_signed();
    int lat, st; logic [31:0] q, r;
    doDiv(32'hFFFF_FFF9, 32'd2, 1'b1, lat, st, q, r);
    nTests++; if (q !== 32'hFFFF_FFFD) begin nFail++; $display("FAIL div_m7_2_quotient got %h exp %h", q, 32'hFFFF_FFFD); end
    nTests++; if (r !== 32'hFFFF_FFFF) begin nFail++; $display("FAIL div_m7_2_remainder got %h exp %h", r, 32'hFFFF_FFFF); end
    doDiv(32'd7, 32'hFFFF_FFFE, 1'b1, lat, st, q, r);
    nTests++; if (q !== 32'hFFFF_FFFD) begin nFail++; $display("FAIL div_7_m2_quotient got %h exp %h", q, 32'hFFFF_FFFD); end
    nTests++; if (r !== 32'd1) begin nFail++; $display("FAIL div_7_m2_remainder got %h exp %h", r, 32'd1); end
    doDiv(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, lat, st, q, r);
    nTests++; if (q !== 32'd3) begin nFail++; $display("FAIL div_m7_m2_quotient got %h exp %h", q, 32'd3); end
    nTests++; if (r !== 32'hFFFF_FFFF) begin nFail++; $display("FAIL div_m7_m2_remainder got %h exp %h", r, 32'hFFFF_FFFF); end
  endtask

  task automatic test_overflow();
    int lat, st; logic [31:0] q, r;
    doDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, st, q, r);
    nTests++; if (q !== 32'h8000_0000) begin nFail++; $display("FAIL overflow_quotient got %h exp %h", q, 32'h8000_0000); end
    nTests++; if (r !== 32'd0) begin nFail++; $display("FAIL overflow_remainder got %h exp %h", r, 32'd0); end
    nTests++; if (lat !== 33) begin nFail++; $display("FAIL overflow_latency got %0d exp 33", lat); end
  endtask

  task automatic test_div_zero();
    int lat, st; logic [31:0] q, r;
    doDiv(32'd5, 32'd0, 1'b0, lat, st, q, r);
    nTests++; if (q !== 32'hFFFF_FFFF) begin nFail++; $display("FAIL dbz_quotient got %h exp %h", q, 32'hFFFF_FFFF); end
    nTests++; if (r !== 32'd5) begin nFail++; $display("FAIL dbz_remainder got %h exp %h", r, 32'd5); end
    nTests++; if (lat !== DBZ_LAT) begin nFail++; $display("FAIL dbz_latency got %0d exp %0d", lat, DBZ_LAT); end
    nTests++; if (st !== DBZ_LAT) begin nFail++; $display("FAIL dbz_stall_cycles got %0d exp %0d", st, DBZ_LAT); end
    // Signed -5/0: magnitudes FFFFFFFF rem 5, then quotient negated (sa^sb) and remainder negated (sa).
    doDiv(32'hFFFF_FFFB, 32'd0, 1'b1, lat, st, q, r);
    nTests++; if (q !== 32'd1) begin nFail++; $display("FAIL dbz_signed_quotient got %h exp %h", q, 32'd1); end
    nTests++; if (r !== 32'hFFFF_FFFB) begin nFail++; $display("FAIL dbz_signed_remainder got %h exp %h", r, 32'hFFFF_FFFB); end
  endtask

  task automatic test_flush();
    int lat, st, nValid; logic [31:0] q, r;
    @(negedge clk);
    opa = 32'd100; opb = 32'd7; signed_div = 1'b0; flush = 1'b0; start = 1'b1;
    for (int i = 0; i < 11; i++) @(negedge clk);
    flush = 1'b1; #1;
    nTests++; if (divstall !== 1'b0) begin nFail++; $display("FAIL flush_busy_divstall got %b exp 0", divstall); end
    nTests++; if (result_valid !== 1'b0) begin nFail++; $display("FAIL flush_busy_valid got %b exp 0", result_valid); end
    @(negedge clk);
    flush = 1'b0; start = 1'b0; #1;
    nTests++; if (divstall !== 1'b0) begin nFail++; $display("FAIL flush_idle_after got divstall %b exp 0", divstall); end
    nValid = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); #1; if (result_valid) nValid++; end
    nTests++; if (nValid !== 0) begin nFail++; $display("FAIL flush_no_result got %0d valid cycles exp 0", nValid); end
    doDiv(32'd9, 32'd3, 1'b0, lat, st, q, r);
    nTests++; if (q !== 32'd3) begin nFail++; $display("FAIL post_flush_quotient got %h exp %h", q, 32'd3); end
    nTests++; if (r !== 32'd0) begin nFail++; $display("FAIL post_flush_remainder got %h exp %h", r, 32'd0); end
    nTests++; if (lat !== 33) begin nFail++; $display("FAIL post_flush_latency got %0d exp 33", lat); end
    // Flush landing in the DONE cycle suppresses the result.
    @(negedge clk);
    opa = 32'd50; opb = 32'd5; start = 1'b1;
    for (int i = 0; i < 33; i++) @(negedge clk);
    start = 1'b0; flush = 1'b1; #1;
    nTests++; if (result_valid !== 1'b0) begin nFail++; $display("FAIL flush_done_valid got %b exp 0", result_valid); end
    @(negedge clk);
    flush = 1'b0; #1;
    nTests++; if (result_valid !== 1'b0) begin nFail++; $display("FAIL flush_done_after_valid got %b exp 0", result_valid); end
  endtask

  task automatic test_back_to_back();
    int lat, st; logic [31:0] q, r;
    doDiv(32'd100, 32'd7, 1'b0, lat, st, q, r);
    // Still in DONE: a new request here must be ignored.
    opa = 32'd9; opb = 32'd3; start = 1'b1; #1;
    nTests++; if (divstall !== 1'b0) begin nFail++; $display("FAIL b2b_done_divstall got %b exp 0", divstall); end
    doDiv(32'd9, 32'd3, 1'b0, lat, st, q, r);
    nTests++; if (lat !== 33) begin nFail++; $display("FAIL b2b_latency got %0d exp 33", lat); end
    nTests++; if (q !== 32'd3) begin nFail++; $display("FAIL b2b_quotient got %h exp %h", q, 32'd3); end
    nTests++; if (r !== 32'd0) begin nFail++; $display("FAIL b2b_remainder got %h exp %h", r, 32'd0); end
  endtask

  task automatic test_reset_mid_busy();
    int nValid;
    @(negedge clk);
    opa = 32'd100; opb = 32'd7; signed_div = 1'b0; flush = 1'b0; start = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    #1; resetn = 1'b0; #1;
    nTests++; if (divstall !== 1'b0) begin nFail++; $display("FAIL rst_mid_divstall got %b exp 0", divstall); end
    nTests++; if (result_valid !== 1'b0) begin nFail++; $display("FAIL rst_mid_valid got %b exp 0", result_valid); end
    nTests++; if (quotient !== 32'd0) begin nFail++; $display("FAIL rst_mid_quotient got %h exp 0", quotient); end
    nTests++; if (remainder !== 32'd0) begin nFail++; $display("FAIL rst_mid_remainder got %h exp 0", remainder); end
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    nValid = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); #1; if (result_valid) nValid++; end
    nTests++; if (nValid !== 0) begin nFail++; $display("FAIL rst_mid_no_result got %0d valid cycles exp 0", nValid); end
  endtask

  initial begin
    nTests = 0; nFail = 0;
    test_reset();
    test_divu();
    test_signed();
    test_overflow();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
